vigenere_stream_decipher: RTL

- Streaming Vigenère decipher engine: recovers plaintext symbols from ciphertext symbols, p = (c - k) mod 26, one symbol per clock.
- Key symbols are loaded once into an internal key register file. The engine then steps through the key cyclically, wrapping at the loaded key length.
- Sits on the receive side of the cipher path, downstream of the encipher stage. Uses valid/ready handshakes on the key, input and output streams.

---
 rtl/vigenere_stream_decipher_if.sv | 44 ++++
 rtl/vigenere_stream_decipher.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vigenere_stream_decipher_if.sv
// Stream bundle for the Vigenere decipher engine: key load port,
// ciphertext input stream and plaintext output stream.
//
// Handshake rule for all three streams (key_*, s_*, m_*): a beat moves
// on a rising clk edge where valid && ready are both high. A source
// holds valid and its payload stable until that edge. A sink may raise
// or drop ready at any time. Ready may depend combinationally on the
// other side's ready, but never on valid.
interface vigenere_stream_decipher_if #(
    parameter int SYM_W = 5
);
    logic             key_valid;
    logic             key_ready;
    logic [SYM_W-1:0] key_data;
    logic             key_last;

    logic             s_valid;
    logic             s_ready;
    logic [SYM_W-1:0] s_data;
    logic             s_last;

    logic             m_valid;
    logic             m_ready;
    logic [SYM_W-1:0] m_data;
    logic             m_last;

    // Upstream / downstream environment side
    modport master (
        output key_valid, key_data, key_last,
        output s_valid, s_data, s_last,
        output m_ready,
        input  key_ready, s_ready,
        input  m_valid, m_data, m_last
    );

    // Decipher engine side
    modport slave (
        input  key_valid, key_data, key_last,
        input  s_valid, s_data, s_last,
        input  m_ready,
        output key_ready, s_ready,
        output m_valid, m_data, m_last
    );
endinterface

// File: rtl/vigenere_stream_decipher.sv
// Streaming Vigenere decipher: p = (c - k) mod 26, one symbol per clock.
// The key is loaded once (IDLE -> LOAD -> RUN), then the key file is
// stepped cyclically. Each message (ended by s_last) restarts at key
// position 0. Results sit in a single output register with a latency
// of one cycle.
//
// Optional build macro VIGENERE_PASSTHRU_EN:
//   defined   - ciphertext 26..31 is forwarded unchanged, the key
//               position does not move for it, and err never sets.
//   undefined - ciphertext 26..31 yields all ones, the key position
//               moves as normal, and err sets sticky until reset.
module vigenere_stream_decipher #(
    parameter int KEY_MAX = 16,
    parameter int SYM_W   = 5,
    localparam int LEN_W  = $clog2(KEY_MAX + 1),
    localparam int IDX_W  = $clog2(KEY_MAX)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    vigenere_stream_decipher_if.slave  bus,
    output logic                       key_loaded,
    output logic                       err,
    output logic [1:0]                 dbg_state,
    output logic [LEN_W-1:0]           dbg_key_len,
    output logic [IDX_W-1:0]           dbg_key_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [SYM_W-1:0] ALPHA     = SYM_W'(26);
    localparam logic [LEN_W-1:0] KEY_MAX_L = LEN_W'(KEY_MAX);

    state_t           state;
    logic [LEN_W-1:0] key_len;
    logic [IDX_W-1:0] key_idx;
    logic [SYM_W-1:0] key_file [KEY_MAX];

    logic             key_ready_q;
    logic             m_valid_q;
    logic [SYM_W-1:0] m_data_q;
    logic             m_last_q;

    logic             key_hs;
    logic             key_store;
    logic [SYM_W-1:0] key_norm;
    logic             s_ready_c;
    logic             s_hs;
    logic             m_hs;
    logic [SYM_W-1:0] key_sym;
    logic [SYM_W-1:0] c_sym;
    logic             c_in_range;
    logic [SYM_W-1:0] plain;
    logic [SYM_W-1:0] result;
    logic             idx_step;
    logic             idx_at_end;
    logic [IDX_W-1:0] idx_next;

    // Key port: key_ready is a registered flag, low only in RUN
    assign key_hs    = bus.key_valid && key_ready_q;
    // Beats past KEY_MAX are still accepted but not stored
    assign key_store = key_hs && (key_len < KEY_MAX_L);
    // Key symbols 26..31 fold back into the alphabet
    assign key_norm  = (bus.key_data >= ALPHA) ? (bus.key_data - ALPHA) : bus.key_data;

    // The output register can take a new beat when empty or draining
    assign s_ready_c = (state == ST_RUN) && (!m_valid_q || bus.m_ready);
    assign s_hs      = bus.s_valid && s_ready_c;
    assign m_hs      = m_valid_q && bus.m_ready;

    assign key_sym    = key_file[key_idx];
    assign c_sym      = bus.s_data;
    assign c_in_range = (c_sym < ALPHA);
    // Both operands lie in 0..25, so the modulo-2^SYM_W wrap of c+26-k
    // still lands on the correct 0..25 result.
    assign plain      = (c_sym >= key_sym) ? (c_sym - key_sym) : (c_sym + ALPHA - key_sym);

`ifdef VIGENERE_PASSTHRU_EN
    assign result   = c_in_range ? plain : c_sym;
    assign idx_step = c_in_range;
`else
    assign result   = c_in_range ? plain : '1;
    assign idx_step = 1'b1;
`endif

    // Wrap after the last loaded key position
    assign idx_at_end = (LEN_W'(key_idx) + LEN_W'(1)) >= key_len;
    assign idx_next   = idx_at_end ? '0 : (key_idx + IDX_W'(1));

    assign bus.key_ready = key_ready_q;
    assign bus.s_ready   = s_ready_c;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_last    = m_last_q;

    assign dbg_state   = state;
    assign dbg_key_len = key_len;
    assign dbg_key_idx = key_idx;

    // Key file storage; contents are meaningless until key_len covers them
    always_ff @(posedge clk) begin
        if (key_store) begin
            key_file[key_len[IDX_W-1:0]] <= key_norm;
        end
    end

    // Control FSM, key position and output register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= ST_IDLE;
            key_len     <= '0;
            key_idx     <= '0;
            key_ready_q <= 1'b1;
            key_loaded  <= 1'b0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            // clear keeps the sticky error, only reset drops it
            if (reset) begin
                err <= 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (key_hs) begin
                        if (key_store) begin
                            key_len <= key_len + LEN_W'(1);
                        end
                        if (bus.key_last) begin
                            state       <= ST_RUN;
                            key_ready_q <= 1'b0;
                            key_loaded  <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_RUN: begin
                    key_ready_q <= 1'b0;
                    key_loaded  <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    key_ready_q <= 1'b1;
                    key_loaded  <= 1'b0;
                end
            endcase

            // s handshakes only happen in RUN, so this is the datapath step
            if (s_hs) begin
                m_valid_q <= 1'b1;
                m_data_q  <= result;
                m_last_q  <= bus.s_last;
                if (bus.s_last) begin
                    key_idx <= '0;
                end else if (idx_step) begin
                    key_idx <= idx_next;
                end
`ifndef VIGENERE_PASSTHRU_EN
                if (!c_in_range) begin
                    err <= 1'b1;
                end
`endif
            end else if (m_hs) begin
                m_valid_q <= 1'b0;
            end
        end
    end

endmodule
